// File: rtl/tile_probe_sequencer.sv
// tile_probe_sequencer: sweeps 8 tile probes around a box and publishes registered collision flags
module tile_probe_sequencer #(
  parameter int TILE_SHIFT = 4,
  parameter int MAP_W = 40,
  parameter int MAP_H = 30,
  parameter int ROM_LAT = 2,
  parameter logic [5:0] EMPTY_COLOR = 6'd0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic [9:0] char_x,
  input  logic [9:0] char_y,
  input  logic [9:0] char_width,
  input  logic [9:0] char_height,
  output logic [6:0] tile_x,
  output logic [6:0] tile_y,
  input  logic [5:0] tile_data,
  output logic       busy,
  output logic       done,
  output logic       collision_left,
  output logic       collision_right,
  output logic       collision_top,
  output logic       collision_bottom,
  output logic       is_grounded
);
  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic [9:0] bx_q, bx_d, by_q, by_d, bw_q, bw_d, bh_q, bh_d;
  logic [3:0] work_q, work_d, flags_q, flags_d;
  logic [6:0] tx_q, ty_q;
  logic [ROM_LAT-1:0] pv_q, pv_d, po_q, po_d;
  logic [ROM_LAT-1:0][2:0] pi_q, pi_d;
  logic signed [10:0] x, y, w, h, px, py;
  logic [10:0] sx, sy;
  logic [2:0] hidx;
  logic issue, accept, last, oob, hit;
  always_comb begin
    x = signed'({1'b0, bx_q});
    y = signed'({1'b0, by_q});
    w = signed'({1'b0, bw_q});
    h = signed'({1'b0, bh_q});
    px = cnt_q[2:1] == 2'd0 ? x - 11'sd1 : cnt_q[2:1] == 2'd1 ? x + w : cnt_q[0] ? x + w - 11'sd1 : x;
    py = cnt_q[2] ? (cnt_q[1] ? y + h : y - 11'sd1) : (cnt_q[0] ? y + h - 11'sd1 : y);
    sx = $unsigned(px) >> TILE_SHIFT;
    sy = $unsigned(py) >> TILE_SHIFT;
    oob = px[10] | py[10] | (sx >= 11'(MAP_W)) | (sy >= 11'(MAP_H));
    issue = state_q == ISSUE;
    accept = state_q == IDLE && start;
    last = cnt_q == 3'(ROM_LAT - 1);
    tile_x = issue ? (px[10] ? 7'd0 : sx[6:0]) : tx_q;
    tile_y = issue ? (py[10] ? 7'd0 : sy[6:0]) : ty_q;
    hidx = pi_q[ROM_LAT-1];
    hit = pv_q[ROM_LAT-1] & (po_q[ROM_LAT-1] | (tile_data != EMPTY_COLOR));
    work_d = accept ? 4'd0 : work_q | (hit ? 4'(4'b1000 >> hidx[2:1]) : 4'd0);
    flags_d = state_q == DRAIN && last ? work_d : flags_q;
    state_d = state_q == IDLE ? (start ? ISSUE : IDLE) :
              state_q == ISSUE ? (cnt_q == 3'd7 ? DRAIN : ISSUE) :
              state_q == DRAIN ? (last ? DONE : DRAIN) : IDLE;
    cnt_d = issue || (state_q == DRAIN && !last) ? cnt_q + 3'd1 : 3'd0;
    bx_d = accept ? char_x : bx_q;
    by_d = accept ? char_y : by_q;
    bw_d = accept ? char_width : bw_q;
    bh_d = accept ? char_height : bh_q;
    pv_d = pv_q;
    po_d = po_q;
    pi_d = pi_q;
    pv_d[0] = issue;
    po_d[0] = oob;
    pi_d[0] = cnt_q;
    for (int i = 1; i < ROM_LAT; i++) begin
      pv_d[i] = pv_q[i-1];
      po_d[i] = po_q[i-1];
      pi_d[i] = pi_q[i-1];
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q <= '0;
      {bx_q, by_q, bw_q, bh_q} <= '0;
      work_q <= '0;
      flags_q <= '0;
      tx_q <= '0;
      ty_q <= '0;
      pv_q <= '0;
      po_q <= '0;
      pi_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      {bx_q, by_q, bw_q, bh_q} <= {bx_d, by_d, bw_d, bh_d};
      work_q <= work_d;
      flags_q <= flags_d;
      tx_q <= tile_x;
      ty_q <= tile_y;
      pv_q <= pv_d;
      po_q <= po_d;
      pi_q <= pi_d;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign {collision_left, collision_right, collision_top, collision_bottom} = flags_q;
  assign is_grounded = flags_q[0];
endmodule

// File: tb/tb_tile_probe_sequencer.sv
// tb_tile_probe_sequencer: directed vectors against three ROM latency builds sharing one tile map
module tb_tile_probe_sequencer;
  logic clk = 0, reset = 1, start = 0;
  logic [9:0] char_x = 0, char_y = 0, char_width = 16, char_height = 16;
  logic [2:0][6:0] tx, ty;
  logic [2:0][5:0] td;
  logic [2:0] busy, done, cl, cr, ct, cb, gr;
  logic solid [30][40];
  int n_chk = 0, n_pass = 0;
  int dc [3], nd [3];
  logic [4:0] fl [3];
  logic [13:0] addr [8];
  logic busy10, busy12;
  logic [4:0] fl10;
  typedef struct {int x, y, w, h, sx, sy; logic [3:0] f;} vec_t;
  vec_t vecs [10];
  always #5 clk = ~clk;
  function automatic logic [5:0] rom(logic [6:0] a, logic [6:0] b);
    if (int'(a) < 40 && int'(b) < 30) return solid[int'(b)][int'(a)] ? 6'd9 : 6'd0;
    return 6'h3F;
  endfunction
  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int LAT = g == 0 ? 1 : g == 1 ? 2 : 4;
    logic [5:0] p [4];
    always @(posedge clk) begin
      p[0] <= rom(tx[g], ty[g]);
      for (int i = 1; i < 4; i++) p[i] <= p[i-1];
    end
    assign td[g] = p[LAT-1];
    tile_probe_sequencer #(.ROM_LAT(LAT)) u_dut (
      .clk(clk), .reset(reset), .start(start),
      .char_x(char_x), .char_y(char_y), .char_width(char_width), .char_height(char_height),
      .tile_x(tx[g]), .tile_y(ty[g]), .tile_data(td[g]),
      .busy(busy[g]), .done(done[g]),
      .collision_left(cl[g]), .collision_right(cr[g]), .collision_top(ct[g]),
      .collision_bottom(cb[g]), .is_grounded(gr[g])
    );
  end
  task automatic chk(string name, int act, int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask
  task automatic set_map(int sx, int sy);
    for (int r = 0; r < 30; r++) for (int c = 0; c < 40; c++) solid[r][c] = 0;
    if (sx >= 0) solid[sy][sx] = 1;
  endtask
  task automatic set_box(int x, int y, int w, int h);
    char_x = 10'(x); char_y = 10'(y); char_width = 10'(w); char_height = 10'(h);
  endtask
  task automatic sweep(int restart_at, int move_at, int rst_at);
    @(posedge clk); #1 start = 1;
    @(posedge clk); #1 start = 0;
    for (int i = 0; i < 3; i++) begin dc[i] = -1; nd[i] = 0; fl[i] = '0; end
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k <= 8) addr[k-1] = {tx[1], ty[1]};
      if (k == 10) begin busy10 = busy[1]; fl10 = {cl[1], cr[1], ct[1], cb[1], gr[1]}; end
      if (k == 12) busy12 = busy[1];
      for (int i = 0; i < 3; i++) if (done[i]) begin
        nd[i]++;
        if (dc[i] < 0) dc[i] = k;
        fl[i] = {cl[i], cr[i], ct[i], cb[i], gr[i]};
      end
      @(posedge clk); #1;
      start = k + 1 == restart_at;
      reset = k + 1 == rst_at;
      if (k + 1 == move_at) char_x = 10'd200;
    end
  endtask
  initial begin
    vecs[0] = '{32, 32, 16, 16, -1, -1, 4'b0000};
    vecs[1] = '{32, 32, 16, 16, 2, 3, 4'b0001};
    vecs[2] = '{32, 31, 16, 16, 2, 3, 4'b0000};
    vecs[3] = '{0, 100, 16, 16, -1, -1, 4'b1000};
    vecs[4] = '{624, 464, 16, 16, -1, -1, 4'b0101};
    vecs[5] = '{32, 32, 16, 16, 1, 2, 4'b1000};
    vecs[6] = '{32, 32, 16, 16, 2, 1, 4'b0010};
    vecs[7] = '{0, 0, 8, 8, -1, -1, 4'b1010};
    vecs[8] = '{32, 32, 1, 1, 2, 2, 4'b0101};
    vecs[9] = '{32, 32, 16, 16, 3, 2, 4'b0100};
    set_map(-1, -1);
    repeat (3) @(posedge clk);
    #1 reset = 0;
    @(negedge clk);
    chk("reset tile_x", int'(tx[1]), 0);
    chk("reset tile_y", int'(ty[1]), 0);
    chk("reset busy", int'(busy[1]), 0);
    chk("reset done", int'(done[1]), 0);
    chk("reset flags", int'({cl[1], cr[1], ct[1], cb[1], gr[1]}), 0);
    set_box(32, 32, 16, 16);
    sweep(0, 0, 0);
    begin
      logic [13:0] ea [8];
      ea = '{{7'd1, 7'd2}, {7'd1, 7'd2}, {7'd3, 7'd2}, {7'd3, 7'd2},
             {7'd2, 7'd1}, {7'd2, 7'd1}, {7'd2, 7'd3}, {7'd2, 7'd3}};
      for (int i = 0; i < 8; i++) chk($sformatf("probe %0d addr", i), int'(addr[i]), int'(ea[i]));
    end
    for (int v = 0; v < 10; v++) begin
      set_map(vecs[v].sx, vecs[v].sy);
      set_box(vecs[v].x, vecs[v].y, vecs[v].w, vecs[v].h);
      sweep(0, 0, 0);
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("vec%0d lat%0d flags", v, i), int'(fl[i]), int'({vecs[v].f, vecs[v].f[0]}));
        chk($sformatf("vec%0d lat%0d done cycle", v, i), dc[i], i == 0 ? 10 : i == 1 ? 11 : 13);
        chk($sformatf("vec%0d lat%0d done count", v, i), nd[i], 1);
      end
    end
    set_map(2, 3);
    set_box(32, 32, 16, 16);
    sweep(3, 2, 0);
    chk("restart flags", int'(fl[1]), 5'b00011);
    chk("restart done cycle", dc[1], 11);
    chk("restart done count", nd[1], 1);
    chk("restart busy after", int'(busy12), 0);
    chk("latched probe7 addr", int'(addr[7]), int'({7'd2, 7'd3}));
    sweep(0, 0, 9);
    chk("abort busy", int'(busy10), 0);
    chk("abort flags", int'(fl10), 0);
    for (int i = 0; i < 3; i++) chk($sformatf("abort lat%0d done count", i), nd[i], 0);
    set_box(32, 32, 16, 16);
    sweep(0, 0, 0);
    chk("post-abort flags", int'(fl[1]), 5'b00011);
    chk("post-abort done cycle", dc[1], 11);
    chk("post-abort done count", nd[1], 1);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
